// File: rtl/spi_slave_xcvr.sv
// SPI mode-0 responder, MSB first. The external sck/cs_n/mosi pins are
// oversampled in the clk domain. Received words are presented on rx_data,
// and transmit words come from a single-entry holding register.
//
// state  | meaning
// IDLE   | cs_n high; miso undriven (0), waiting for a cs_n fall
// ACTIVE | selected; shifting rx on sck rise and tx on sck fall
module spi_slave_xcvr #(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_TX = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sck,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  frame_abort
);

    localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic sck_s1, sck_s2, sck_s3;
    logic cs_s1, cs_s2, cs_s3;
    logic mosi_s1, mosi_s2;

    logic                  sck_rise, sck_fall, cs_fall, cs_rise;
    logic [0:0]            state;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  word_done;
    logic                  got_rise;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-2:0] rx_shift;
    logic [DATA_WIDTH-1:0] rx_next;
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  hold_full;
    logic                  load_word;
    logic                  accept;

    // Two-flop synchronisers. The third sck/cs_n stage is used only for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_s1  <= 1'b0;
            sck_s2  <= 1'b0;
            sck_s3  <= 1'b0;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            cs_s3   <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            sck_s1  <= sck;
            sck_s2  <= sck_s1;
            sck_s3  <= sck_s2;
            cs_s1   <= cs_n;
            cs_s2   <= cs_s1;
            cs_s3   <= cs_s2;
            mosi_s1 <= mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    assign sck_rise = sck_s2 & ~sck_s3;
    assign sck_fall = ~sck_s2 & sck_s3;
    assign cs_fall  = ~cs_s2 & cs_s3;
    assign cs_rise  = cs_s2 & ~cs_s3;

    assign rx_next  = {rx_shift, mosi_s2};
    assign tx_ready = ~hold_full;
    assign accept   = tx_valid & ~hold_full;
    assign miso_oe  = (state == ACTIVE);
    assign miso     = (state == ACTIVE) ? tx_shift[DATA_WIDTH-1] : 1'b0;

    // A new transmit word is taken at frame start and at each word boundary.
    always_comb begin
        load_word = 1'b0;
        if (state == IDLE) begin
            load_word = cs_fall;
        end else if (!cs_rise && sck_fall && got_rise && word_done) begin
            load_word = 1'b1;
        end
    end

    // Single-entry holding register. A load only drains it when it is full,
    // so a load and an accept can never collide on the same entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (load_word && hold_full) begin
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_data <= tx_data;
        end
    end

    // Frame FSM: shift registers, bit counter and the one-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            word_done   <= 1'b0;
            got_rise    <= 1'b0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (cs_fall) begin
                        state       <= ACTIVE;
                        word_done   <= 1'b0;
                        got_rise    <= 1'b0;
                        tx_shift    <= hold_full ? hold_data : DEFAULT_TX;
                        tx_underrun <= ~hold_full;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state       <= IDLE;
                        bit_cnt     <= '0;
                        word_done   <= 1'b0;
                        frame_abort <= (bit_cnt != '0);
                    end else begin
                        if (sck_rise) begin
                            rx_shift <= rx_next[DATA_WIDTH-2:0];
                            got_rise <= 1'b1;
                            if (bit_cnt == LAST_BIT) begin
                                rx_data   <= rx_next;
                                rx_valid  <= 1'b1;
                                bit_cnt   <= '0;
                                word_done <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                        // A fall before the first rise of the frame would
                        // discard the preloaded MSB, so it is ignored.
                        if (sck_fall && got_rise) begin
                            if (word_done) begin
                                tx_shift    <= hold_full ? hold_data : DEFAULT_TX;
                                tx_underrun <= ~hold_full;
                                word_done   <= 1'b0;
                            end else begin
                                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_xcvr.sv
// Directed and random bench for spi_slave_xcvr. A master model drives the
// pins at clk/8. Expected transmit words come from a queue model of the
// holding register.
module tb_spi_slave_xcvr;

    localparam logic [7:0] DEF = 8'h00;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sck = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       miso, miso_oe, tx_ready, rx_valid, tx_underrun, frame_abort;
    logic [7:0] rx_data;

    spi_slave_xcvr #(.DATA_WIDTH(8), .DEFAULT_TX(DEF)) dut (
        .clk(clk), .rst_n(rst_n), .sck(sck), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_underrun(tx_underrun), .frame_abort(frame_abort)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_rxv = 0, n_und = 0, n_abt = 0;
    int exp_und = 0;
    logic [7:0] tx_q[$];
    logic [7:0] cur_exp;

    always @(negedge clk) begin
        if (rx_valid)    n_rxv++;
        if (tx_underrun) n_und++;
        if (frame_abort) n_abt++;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: the next word the responder must shift is the oldest accepted
    // word, or the default with an underrun when none is waiting.
    task automatic model_load(output logic [7:0] w);
        if (tx_q.size() > 0) begin
            w = tx_q.pop_front();
        end else begin
            w = DEF;
            exp_und++;
        end
    endtask

    task automatic push(input logic [7:0] d);
        int t = 0;
        while (!tx_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("push_ready", {31'd0, tx_ready}, 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_q.push_back(d);
    endtask

    task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[7-i];
            clks(4);
            mi = {mi[6:0], miso};
            sck = 1'b1;
            clks(4);
            sck = 1'b0;
        end
    endtask

    task automatic word(input logic [7:0] mo, input string tag);
        logic [7:0] mi;
        xfer(mo, 8, mi);
        chk($sformatf("%s_miso", tag), {24'd0, mi}, {24'd0, cur_exp});
        chk($sformatf("%s_rx", tag), {24'd0, rx_data}, {24'd0, mo});
        model_load(cur_exp);
    endtask

    task automatic frame_start();
        cs_n = 1'b0;
        model_load(cur_exp);
        clks(6);
    endtask

    task automatic frame_end();
        clks(4);
        cs_n = 1'b1;
        clks(6);
    endtask

    task automatic chk_reset(input string tag);
        chk($sformatf("%s_miso", tag), {31'd0, miso}, 32'd0);
        chk($sformatf("%s_oe", tag), {31'd0, miso_oe}, 32'd0);
        chk($sformatf("%s_rxd", tag), {24'd0, rx_data}, 32'd0);
        chk($sformatf("%s_rxv", tag), {31'd0, rx_valid}, 32'd0);
        chk($sformatf("%s_rdy", tag), {31'd0, tx_ready}, 32'd1);
        chk($sformatf("%s_und", tag), {31'd0, tx_underrun}, 32'd0);
        chk($sformatf("%s_abt", tag), {31'd0, frame_abort}, 32'd0);
    endtask

    initial begin
        int rxv0, abt0;
        logic [7:0] mi;

        clks(3);
        chk_reset("reset");
        rst_n = 1'b1;
        clks(3);

        // Single word: A5 out, 3C in.
        rxv0 = n_rxv;
        push(8'hA5);
        chk("t1_ready_drop", {31'd0, tx_ready}, 32'd0);
        frame_start();
        chk("t1_oe", {31'd0, miso_oe}, 32'd1);
        word(8'h3C, "t1");
        chk("t1_rxv_cnt", n_rxv - rxv0, 32'd1);
        frame_end();
        chk("t1_oe_off", {31'd0, miso_oe}, 32'd0);
        chk("t1_und_cnt", n_und, exp_und);

        // Back-to-back words, holding register refilled during word 1.
        rxv0 = n_rxv;
        push(8'h96);
        frame_start();
        fork
            word(8'hC9, "t2a");
            begin
                clks(16);
                push(8'h5A);
            end
        join
        word(8'h7E, "t2b");
        frame_end();
        chk("t2_rxv_cnt", n_rxv - rxv0, 32'd2);
        chk("t2_und_cnt", n_und, exp_und);

        // Frame started with the holding register empty.
        frame_start();
        chk("t3_und_start", n_und, exp_und);
        word(8'h81, "t3");
        frame_end();

        // Abort after 5 bits; the holding register keeps its word.
        push(8'h33);
        frame_start();
        push(8'h44);
        rxv0 = n_rxv;
        abt0 = n_abt;
        xfer(8'hFF, 5, mi);
        chk("t4_partial_miso", {27'd0, mi[4:0]}, {27'd0, 5'b00110});
        clks(4);
        cs_n = 1'b1;
        clks(6);
        chk("t4_abort_cnt", n_abt - abt0, 32'd1);
        chk("t4_no_rxv", n_rxv - rxv0, 32'd0);
        chk("t4_oe_off", {31'd0, miso_oe}, 32'd0);
        chk("t4_hold_full", {31'd0, tx_ready}, 32'd0);
        frame_start();
        word(8'hB2, "t4");
        frame_end();

        // Reset after 3 bits with cs_n held low, then a fresh word.
        frame_start();
        xfer(8'hF0, 3, mi);
        rst_n = 1'b0;
        tx_q.delete();
        clks(2);
        chk_reset("t5_rst");
        rst_n = 1'b1;
        model_load(cur_exp);
        clks(8);
        word(8'hC3, "t5");
        frame_end();
        chk("t5_und_cnt", n_und, exp_und);
        chk("t5_abt_none", n_abt - abt0, 32'd1);

        // 256 random words in one frame at clk/8.
        rxv0 = n_rxv;
        push(8'($urandom));
        frame_start();
        push(8'($urandom));
        for (int k = 0; k < 256; k++) begin
            word(8'($urandom), "rnd");
            clks(4);
            push(8'($urandom));
        end
        frame_end();
        chk("rnd_rxv_cnt", n_rxv - rxv0, 32'd256);
        chk("rnd_und_cnt", n_und, exp_und);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
